hilo_unit: RTL and testbench

//  HI/LO special-register unit sitting directly downstream of the ALU in the mMIPS EX stage.
//  - Captures the 64-bit MULTU product delivered by the ALU (r = low word, r2 = high word).
//  - Runs an iterative DIV/DIVU (restoring, 1 quotient bit/cycle) and serves MTHI/MTLO.
//  - Drives hi/lo to the MFHI/MFLO result mux and a busy stall to the pipeline controller.

---
 rtl/hilo_unit_pkg.sv | 19 +
 rtl/hilo_unit_div_iter.sv | 63 ++++++
 rtl/hilo_unit.sv | 145 ++++++++++++++
 tb/tb_hilo_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: opcode encodings, default width and FSM states.
package hilo_unit_pkg;

    localparam int HILO_DATA_W = 32;

    localparam logic [2:0] HILO_OP_NOP   = 3'd0;
    localparam logic [2:0] HILO_OP_WRMUL = 3'd1;
    localparam logic [2:0] HILO_OP_DIVU  = 3'd2;
    localparam logic [2:0] HILO_OP_DIV   = 3'd3;
    localparam logic [2:0] HILO_OP_MTHI  = 3'd4;
    localparam logic [2:0] HILO_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_unit_div_iter.sv
// Restoring shift-subtract divider core: one quotient bit per step, plus iteration counter.
module hilo_unit_div_iter
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quo,
    output logic [DATA_W-1:0] rem,
    output logic              last
);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_p1;
    logic [DATA_W-1:0] quo_p1;
    logic [DATA_W-1:0] dvs_p1;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // Working remainder is one bit wider so the trial subtract's borrow lands in the MSB.
    always_comb begin
        shifted = {rem_p1, quo_p1[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_p1};
    end

    assign last = (cnt == CNT_W'(DATA_W - 1));
    assign quo  = quo_p1;
    assign rem  = rem_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Stage boundary: the dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_p1 <= '0;
            quo_p1 <= dividend;
            dvs_p1 <= divisor;
        end else if (step) begin
            if (!diff[DATA_W]) begin
                rem_p1 <= diff[DATA_W-1:0];
                quo_p1 <= {quo_p1[DATA_W-2:0], 1'b1};
            end else begin
                rem_p1 <= shifted[DATA_W-1:0];
                quo_p1 <= {quo_p1[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO special-register unit: captures MULTU products, serves MTHI/MTLO and runs an iterative DIV/DIVU.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] alu_lo,
    input  logic [DATA_W-1:0] alu_hi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    hilo_state_e       state;
    hilo_state_e       state_nxt;
    logic              accept;
    logic              is_div;
    logic              is_signed;
    logic              div_load;
    logic              div_step;
    logic              div_zero;
    logic              fix_wr;
    logic              div_last;
    logic              neg_quo_p1;
    logic              neg_rem_p1;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic use_sign);
        logic signed [DATA_W-1:0] neg_v;
        neg_v = -v;
        return (use_sign && v[DATA_W-1]) ? $unsigned(neg_v) : $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign is_div    = (op == HILO_OP_DIVU) || (op == HILO_OP_DIV);
    assign is_signed = (op == HILO_OP_DIV);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        div_zero  = 1'b0;
        fix_wr    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = op_valid;
                if (op_valid && is_div) begin
                    if (b == '0) begin
                        div_zero = 1'b1;
                    end else begin
                        div_load  = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                div_step = 1'b1;
                if (div_last) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                fix_wr    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage boundary: operands enter the divider as magnitudes; signs are kept for the fix-up.
    always_ff @(posedge clk) begin
        if (div_load) begin
            neg_quo_p1 <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_rem_p1 <= is_signed && a[DATA_W-1];
        end
    end

    hilo_unit_div_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (magnitude(a, is_signed)),
        .divisor  (magnitude(b, is_signed)),
        .quo      (quo),
        .rem      (rem),
        .last     (div_last)
    );

    // Stage boundary: architectural HI/LO and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= div_zero || fix_wr;
            if (fix_wr) begin
                lo <= cond_neg(quo, neg_quo_p1);
                hi <= cond_neg(rem, neg_rem_p1);
            end else if (accept) begin
                case (op)
                    HILO_OP_WRMUL: begin
                        lo <= alu_lo;
                        hi <= alu_hi;
                    end
                    HILO_OP_MTHI: hi <= a;
                    HILO_OP_MTLO: lo <= a;
                    HILO_OP_DIVU, HILO_OP_DIV: begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= a;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed corner cases plus randomized ops against a reference model.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] alu_lo = '0;
    logic [W-1:0] alu_hi = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;

    hilo_unit #(.DATA_W(W), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .alu_lo   (alu_lo),
        .alu_hi   (alu_hi),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference divide from plain integer arithmetic; returns {hi, lo}.
    function automatic logic [2*W-1:0] ref_div(input bit sgn, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint sx, sy, q, r;
        if (y == '0) return {x, {W{1'b1}}};
        if (!sgn) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = sx / sy;
        r = sx % sy;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", busy, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) check("done_timeout", done, 1);
    endtask

    // Drives one op across a single rising edge, then scrambles inputs to prove latching.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ml, input logic [W-1:0] mh);
        op_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        alu_lo = ml;
        alu_hi = mh;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        alu_lo = $urandom;
        alu_hi = $urandom;
        case (o)
            HILO_OP_WRMUL: begin m_lo = ml; m_hi = mh; end
            HILO_OP_MTHI:  m_hi = x;
            HILO_OP_MTLO:  m_lo = x;
            HILO_OP_DIVU, HILO_OP_DIV: begin
                {m_hi, m_lo} = ref_div(o == HILO_OP_DIV, x, y);
                exp_q.push_back({m_hi, m_lo});
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ml, input logic [W-1:0] mh);
        @(negedge clk);
        wait_idle();
        issue(o, x, y, ml, mh);
        if (o != HILO_OP_DIVU && o != HILO_OP_DIV) begin
            @(negedge clk);
            check("regs_after_op", {hi, lo}, {m_hi, m_lo});
            check("done_low_non_div", done, 0);
        end
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding divide.
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("div_result", {hi, lo}, e);
                end
            end
        end
    end

    initial begin
        int nb;
        int done_at;
        int seen;
        int n;
        logic [2:0]   o;
        logic [W-1:0] x, y;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b1;

        run_op(HILO_OP_WRMUL, 0, 0, 32'h1, 32'h2);
        check("wrmul_lo", lo, 1);
        check("wrmul_hi", hi, 2);
        check("wrmul_busy", busy, 0);

        @(negedge clk);
        wait_idle();
        issue(HILO_OP_DIVU, 100, 7, 0, 0);
        nb = 0;
        done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                done_at = k;
                break;
            end
        end
        check("divu_busy_cycles", nb, 33);
        check("divu_done_cycle", done_at, 34);
        check("divu_busy_at_done", busy, 0);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

        @(negedge clk);
        issue(HILO_OP_DIV, 32'hFFFF_FFF9, 2, 0, 0);
        wait_done();
        check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        @(negedge clk);
        issue(HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        wait_done();
        check("div_overflow", {hi, lo}, {32'h0, 32'h8000_0000});

        @(negedge clk);
        issue(HILO_OP_DIVU, 5, 0, 0, 0);
        @(negedge clk);
        check("div0_busy", busy, 0);
        check("div0_done", done, 1);
        check("div0_regs", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

        @(negedge clk);
        issue(HILO_OP_DIVU, 1000, 10, 0, 0);
        repeat (10) @(negedge clk);
        op_valid = 1'b1;
        op = HILO_OP_MTLO;
        a = 9;
        @(negedge clk);
        op_valid = 1'b0;
        wait_done();
        check("mtlo_while_busy", {hi, lo}, {32'd0, 32'd100});

        @(negedge clk);
        issue(HILO_OP_DIVU, $urandom, $urandom_range(1, 1000), 0, 0);
        repeat (16) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        check("midrun_reset_regs", {hi, lo}, 0);
        check("midrun_reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", seen, 0);
        issue(HILO_OP_DIVU, 9, 3, 0, 0);
        wait_done();
        check("divu_9_3_after_reset", {hi, lo}, {32'd0, 32'd3});

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rand_val();
            y = ($urandom_range(0, 5) == 0) ? '0 : rand_val();
            run_op(o, x, y, $urandom, $urandom);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
